ctrl_pipe_reg: RTL
==================

Name: ctrl_pipe_reg

Overview:
- Parametrised control-signal pipeline register for the RISC-V pipeline.
- Replaces the fixed single-stage EX/MEM control latch with a configurable chain:
  - configurable WIDTH and DEPTH;
  - per-stage valid bit;
  - stall (hold) and flush (bubble insertion);
  - occupancy tracking.
- Sits between hazard unit / decode control outputs and downstream stages (E->M, M->W, or multi-cycle paths).

Parameters:
- WIDTH, 4, bits of packed control word per stage (e.g. {RegWrite, MemWrite, ResultSrc[1:0]}); legal range 1 to 64.
- DEPTH, 1, number of register stages; legal range 1 to 8; in-to-out latency in cycles.
- BUBBLE_VAL, 0, WIDTH-bit value driven on data of any invalid stage (must de-assert all write enables).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- stall_i  input  1  hold all stages this cycle
- flush_i  input  1  invalidate all stages this cycle
- in_valid_i  input  1  entry at input is a real instruction
- in_data_i  input  WIDTH  control word for stage 0
- out_valid_o  output  1  valid bit of stage DEPTH-1
- out_data_o  output  WIDTH  data of stage DEPTH-1 (BUBBLE_VAL when out_valid_o=0)
- occ_o  output  $clog2(DEPTH+1)  count of valid stages
- stall_cnt_o  output  16  stall cycle counter (optional feature)
- flush_cnt_o  output  16  flush event counter (optional feature)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- State: stages s[0..DEPTH-1], each holding valid v[i] and data d[i]. Outputs come directly from s[DEPTH-1]; no combinational in->out path.
- Reset (async, while rst=1):
  - all v[i]=0, d[i]=BUBBLE_VAL;
  - occ_o=0, stall_cnt_o=0, flush_cnt_o=0;
  - out_valid_o=0, out_data_o=BUBBLE_VAL.
  - Reset asserted mid-operation discards all in-flight entries immediately, without waiting for a clock edge.
- Per-edge priority: rst > flush_i > stall_i > advance.
- Flush (flush_i=1):
  - all v[i]<=0, all d[i]<=BUBBLE_VAL, regardless of stall_i or in_valid_i;
  - the input entry presented that cycle is dropped.
- Stall (stall_i=1, flush_i=0): all stages hold; the input is not captured. The upstream stage is responsible for holding its input.
- Advance (both 0):
  - v[0]<=in_valid_i; d[0]<=in_valid_i ? in_data_i : BUBBLE_VAL;
  - for i>=1: v[i]<=v[i-1], d[i]<=d[i-1];
  - the entry in s[DEPTH-1] retires.
- Invariant: v[i]=0 implies d[i]=BUBBLE_VAL at all times.
- Latency: entry captured at edge N appears on out_*_o after edge N+DEPTH-1, i.e. exactly DEPTH edges of advance from the input. With DEPTH=1 the behaviour is a plain latch plus stall/flush.
- occ_o:
  - registered, updated on the same edge as the stages;
  - must equal popcount(v) after every edge;
  - advance: occ + in_valid_i - v[DEPTH-1]; stall: unchanged; flush: 0;
  - never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- Defined:
  - stall_cnt_o increments on every edge with stall_i=1 and flush_i=0;
  - flush_cnt_o increments on every edge with flush_i=1;
  - both are 16-bit and saturate at 16'hFFFF (no wrap);
  - both clear only on rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised. Pipeline behaviour is identical either way.

Test Plan:
- Reset mid-operation: WIDTH=4, DEPTH=2, BUBBLE_VAL=0. Push 4'hA then 4'h5 with valid=1, then assert rst between edges -> out_valid_o=0, out_data_o=0, occ_o=0 immediately. After release, the first new entry appears 2 edges later.
- Latency and bubbles: DEPTH=3. Inputs valid 1,0,1 with data 4'h1, 4'h7, 4'h3 -> outputs on edges 3,4,5 are (1,4'h1), (0,4'h0), (1,4'h3). occ_o sequence is 1,1,2,1 (edges 1 to 4).
- Stall hold: DEPTH=2, pipeline holding 4'h9 (s1) and 4'h6 (s0). Hold stall_i=1 for 3 edges with in_data_i=4'hF -> out_data_o stays 4'h9 and occ_o stays 2. After release, 4'h6 emerges next edge; 4'hF is captured only if still presented.
- Flush beats stall: DEPTH=2, full pipeline. Assert stall_i=1 and flush_i=1 on the same edge, with in_valid_i=1 -> all v=0, out_data_o=0, occ_o=0. The input entry is dropped.
- Non-zero bubble: BUBBLE_VAL=4'h8, DEPTH=1. in_valid_i=0 with in_data_i=4'h3 -> out_data_o=4'h8, out_valid_o=0.
- Counters, with CTRL_PIPE_PERF_EN defined: 5 stall edges plus 2 flush edges -> stall_cnt_o=5, flush_cnt_o=2. 70000 stall edges -> stall_cnt_o=16'hFFFF. With the macro undefined, both outputs stay 0.

Source files
------------

// File: rtl/ctrl_pipe_reg.sv
// rtl/ctrl_pipe_reg.sv - parametrised control-word pipeline register with stall, flush and occupancy
// Optional performance counters are enabled by defining CTRL_PIPE_PERF_EN.

module ctrl_pipe_reg #(
    parameter int                 WIDTH      = 4,
    parameter int                 DEPTH      = 1,
    parameter logic [WIDTH-1:0]   BUBBLE_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         out_valid_o,
    output logic [WIDTH-1:0]             out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o,
    output logic [15:0]                  stall_cnt_o,
    output logic [15:0]                  flush_cnt_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [OCC_W-1:0] occ_q;

    // Invalid stages always carry BUBBLE_VAL so downstream write enables stay low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= BUBBLE_VAL;
            end
        end else if (flush_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= BUBBLE_VAL;
            end
        end else if (!stall_i) begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_valid_i ? in_data_i : BUBBLE_VAL;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
            occ_q <= occ_q + OCC_W'(in_valid_i) - OCC_W'(valid_q[DEPTH-1]);
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];
    assign occ_o       = occ_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (flush_i) begin
                if (flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
            end else if (stall_i) begin
                if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 16'd0;
    assign flush_cnt_o = 16'd0;
`endif

endmodule
